transport_tx_mux: RTL

TRANSPORT_TX_MUX -- requirements
Module: transport_tx_mux

---
 rtl/transport_pkg.sv | 44 ++++
 rtl/transport_fifo.sv | 56 +++++
 rtl/transport_tx_mux.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/transport_pkg.sv
// ============================================================================
// Module   : transport_pkg
// Brief    : Shared FSM state type, header packing and channel-index sizing
//            for the transport transmit multiplexer.
// Config   : TRANSPORT_CHKSUM_EN adds the checksum state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package transport_pkg;

`ifdef TRANSPORT_CHKSUM_EN
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CHK     = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;
`endif

   localparam int HDR_MAX_W = 64;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int ch_idx_w(input int ch);
      return (ch > 1) ? $clog2(ch) : 1;
   endfunction

   function automatic logic [HDR_MAX_W-1:0] pack_header(
      input logic [HDR_MAX_W-1:0] dest,
      input logic [HDR_MAX_W-1:0] chan,
      input int                   low_w
   );
      return (dest << low_w) | chan;
   endfunction

endpackage

`default_nettype wire

// File: rtl/transport_fifo.sv
// ============================================================================
// Module   : transport_fifo
// Brief    : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module transport_fifo #(
   parameter int DW    = 16,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DW-1:0]          wdata,
   input  logic                   pop,
   output logic [DW-1:0]          rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/transport_tx_mux.sv
// ============================================================================
// Module   : transport_tx_mux
// Brief    : Per-channel FIFOs merged round-robin into one packetised link
//            (header, PKT_LEN payload words, optional XOR checksum word).
// Config   : define TRANSPORT_CHKSUM_EN to append the checksum word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module transport_tx_mux
   import transport_pkg::*;
#(
   parameter int DW      = 16,
   parameter int CH      = 2,
   parameter int DEPTH   = 16,
   parameter int PKT_LEN = 8,
   parameter int PHONE_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CH-1:0]         chan_en,
   input  logic [CH*PHONE_W-1:0] dest_num,
   input  logic [CH*DW-1:0]      in_data,
   input  logic [CH-1:0]         in_valid,
   output logic [CH-1:0]         in_ready,
   output logic [DW-1:0]         out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic [CH-1:0]         overflow,
   output logic                  busy
);
   localparam int CIW = ch_idx_w(CH);
   localparam int CW  = $clog2(DEPTH) + 1;

   if (DW < PHONE_W + CIW) begin : g_bad_cfg
      $error("transport_tx_mux: DW too narrow for phone number plus channel index");
   end

   logic [CW-1:0]      count [CH];
   logic [DW-1:0]      rdata [CH];
   logic [CH-1:0]      push;
   logic [CH-1:0]      pop;
   logic [CH-1:0]      eligible;
   logic               any_eligible;
   logic [CIW-1:0]     next_grant;
   logic [CIW-1:0]     grant;
   logic [CIW-1:0]     rr;
   logic [CW-1:0]      words;
   logic [PHONE_W-1:0] dest_sel;
   logic [DW-1:0]      hdr_word;
   logic               handshake;
   logic               last_payload;
   logic               load_word;
   int                 idx;
   state_t             state;
`ifdef TRANSPORT_CHKSUM_EN
   logic [DW-1:0]      chk;
`endif

   for (genvar k = 0; k < CH; k++) begin : g_chan
      assign in_ready[k] = (count[k] != CW'(DEPTH));
      assign push[k]     = in_valid[k] & in_ready[k];
      assign eligible[k] = chan_en[k] & (count[k] >= CW'(PKT_LEN));
      assign pop[k]      = load_word & (grant == CIW'(k));

      transport_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[k]),
         .wdata (in_data[k*DW +: DW]),
         .pop   (pop[k]),
         .rdata (rdata[k]),
         .count (count[k])
      );

      always_ff @(posedge clk) begin
         if (reset) begin
            overflow[k] <= 1'b0;
         end else if (in_valid[k] & !in_ready[k]) begin
            overflow[k] <= 1'b1;
         end
      end
   end

   // Scan downward so the channel closest after rr wins.
   always_comb begin
      any_eligible = 1'b0;
      next_grant   = '0;
      idx          = 0;
      for (int i = CH - 1; i >= 0; i--) begin
         idx = int'(rr) + i;
         if (idx >= CH) begin
            idx = idx - CH;
         end
         if (eligible[idx[CIW-1:0]]) begin
            any_eligible = 1'b1;
            next_grant   = idx[CIW-1:0];
         end
      end
   end

   assign dest_sel     = dest_num[int'(next_grant)*PHONE_W +: PHONE_W];
   assign hdr_word     = DW'(pack_header(HDR_MAX_W'(dest_sel), HDR_MAX_W'(next_grant), DW - PHONE_W));
   assign handshake    = out_valid & out_ready;
   assign last_payload = (words == CW'(PKT_LEN));
   // A payload word leaves its FIFO when it is loaded into the output register.
   assign load_word    = handshake & ((state == ST_HDR) | ((state == ST_PAYLOAD) & !last_payload));
   assign busy         = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         grant     <= '0;
         rr        <= '0;
         words     <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_data  <= '0;
`ifdef TRANSPORT_CHKSUM_EN
         chk       <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_eligible) begin
                  state     <= ST_HDR;
                  grant     <= next_grant;
                  rr        <= (int'(next_grant) == CH - 1) ? '0 : next_grant + CIW'(1);
                  words     <= '0;
                  out_valid <= 1'b1;
                  out_sop   <= 1'b1;
                  out_eop   <= 1'b0;
                  out_data  <= hdr_word;
               end
            end
            ST_HDR: begin
               if (handshake) begin
                  state    <= ST_PAYLOAD;
                  words    <= CW'(1);
                  out_sop  <= 1'b0;
                  out_data <= rdata[grant];
`ifdef TRANSPORT_CHKSUM_EN
                  chk      <= out_data;
                  out_eop  <= 1'b0;
`else
                  out_eop  <= (PKT_LEN == 1);
`endif
               end
            end
            ST_PAYLOAD: begin
               if (handshake) begin
                  if (last_payload) begin
`ifdef TRANSPORT_CHKSUM_EN
                     state     <= ST_CHK;
                     out_data  <= chk ^ out_data;
                     out_eop   <= 1'b1;
`else
                     state     <= ST_IDLE;
                     out_valid <= 1'b0;
                     out_eop   <= 1'b0;
`endif
                  end else begin
                     words    <= words + CW'(1);
                     out_data <= rdata[grant];
`ifdef TRANSPORT_CHKSUM_EN
                     chk      <= chk ^ out_data;
`else
                     out_eop  <= (words == CW'(PKT_LEN - 1));
`endif
                  end
               end
            end
`ifdef TRANSPORT_CHKSUM_EN
            ST_CHK: begin
               if (handshake) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  out_eop   <= 1'b0;
               end
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
